noc_ni_local: RTL

NOC_NI_LOCAL -- requirements
Module: noc_ni_local

---
 rtl/noc_ni_local_if.sv | 36 +++
 rtl/noc_ni_local.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/noc_ni_local_if.sv
// Link bundle of the local network interface: PE request/write/read channels plus router TX/RX.
// The master modport is the NI side; the slave modport is the PE/router environment.
interface noc_ni_local_if;
    logic        pe_req_valid;
    logic        pe_req_ready;
    logic [3:0]  pe_req_dst;
    logic [11:0] pe_req_len;
    logic [27:0] pe_wdata;
    logic        pe_wvalid;
    logic        pe_wready;
    logic [31:0] TX;
    logic        RTS;
    logic        DCTS;
    logic [31:0] RX;
    logic        DRTS;
    logic        CTS;
    logic [27:0] pe_rdata;
    logic [2:0]  pe_rtype;
    logic [3:0]  pe_rsrc;
    logic        pe_rvalid;
    logic        pe_rready;

    modport master (
        input  pe_req_valid, pe_req_dst, pe_req_len, pe_wdata, pe_wvalid,
        input  DCTS, RX, DRTS, pe_rready,
        output pe_req_ready, pe_wready, TX, RTS, CTS,
        output pe_rdata, pe_rtype, pe_rsrc, pe_rvalid
    );

    modport slave (
        output pe_req_valid, pe_req_dst, pe_req_len, pe_wdata, pe_wvalid,
        output DCTS, RX, DRTS, pe_rready,
        input  pe_req_ready, pe_wready, TX, RTS, CTS,
        input  pe_rdata, pe_rtype, pe_rsrc, pe_rvalid
    );
endinterface

// File: rtl/noc_ni_local.sv
// Local NoC network interface: packetises PE words into parity-protected flits and buffers inbound flits.
// Define NI_PARITY_CHECK_EN to count inbound parity errors in rx_err_cnt.
module noc_ni_local (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         cur_addr,
    noc_ni_local_if.master     bus,
    output logic [7:0]         rx_err_cnt
);
    typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} tx_state_t;

    localparam logic [2:0] TYPE_HDR  = 3'b001;
    localparam logic [2:0] TYPE_BODY = 3'b010;
    localparam logic [2:0] TYPE_TAIL = 3'b100;

    function automatic logic parity_odd(input logic [31:0] flit);
        return ^flit;
    endfunction

    function automatic logic [31:0] make_flit(input logic [2:0] typ, input logic [27:0] body);
        return {typ, body, ^{typ, body}};
    endfunction

    tx_state_t   state_q, state_d;
    logic [11:0] len_q, len_d;
    logic [3:0]  dst_q, dst_d;
    logic [11:0] cnt_q, cnt_d;
    logic [31:0] tx_q, tx_d;
    logic        rts_q, rts_d;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rts_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.pe_req_valid) begin
                    dst_d   = bus.pe_req_dst;
                    len_d   = (bus.pe_req_len < 12'd2) ? 12'd2 : bus.pe_req_len;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (bus.DCTS) begin
                    tx_d    = make_flit(TYPE_HDR, {len_q, dst_q, cur_addr, 8'h00});
                    cnt_d   = len_q - 12'd1;
                    rts_d   = 1'b1;
                    state_d = GAP;
                end
            end
            PAY: begin
                if (bus.DCTS && bus.pe_wvalid) begin
                    tx_d    = make_flit((cnt_q == 12'd1) ? TYPE_TAIL : TYPE_BODY, bus.pe_wdata);
                    cnt_d   = cnt_q - 12'd1;
                    rts_d   = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                // One dead cycle after every launch keeps RTS a single-cycle pulse.
                state_d = (cnt_q != 12'd0) ? PAY : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 12'd0;
            tx_q    <= 32'd0;
            rts_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rts_q   <= rts_d;
        end
    end

    always_ff @(posedge clk) begin
        len_q <= len_d;
        dst_q <= dst_d;
    end

    assign bus.pe_req_ready = (state_q == IDLE);
    assign bus.pe_wready    = (state_q == PAY) && bus.DCTS;
    assign bus.TX           = tx_q;
    assign bus.RTS          = rts_q;

    // Inbound FIFO stores flit bits [31:1]; the parity bit is only needed for checking.
    logic [30:0] fifo_mem [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  occ;
    logic        pop, wr_en;
    logic [30:0] head;
    logic [3:0]  rsrc_q;

    assign head  = fifo_mem[rd_ptr];
    assign pop   = (occ != 2'd0) && bus.pe_rready;
    assign wr_en = bus.DRTS && ((occ != 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
            rsrc_q <= 4'd0;
        end else begin
            if (wr_en) wr_ptr <= ~wr_ptr;
            if (pop)   rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, wr_en} - {1'b0, pop};
            if (pop && (head[30:28] == TYPE_HDR)) rsrc_q <= head[11:8];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem[wr_ptr] <= bus.RX[31:1];
    end

    // Only an empty FIFO grants CTS, so a flit already in flight always has a slot.
    assign bus.CTS       = (occ == 2'd0);
    assign bus.pe_rvalid = (occ != 2'd0);
    assign bus.pe_rdata  = head[27:0];
    assign bus.pe_rtype  = head[30:28];
    assign bus.pe_rsrc   = rsrc_q;

`ifdef NI_PARITY_CHECK_EN
    logic [7:0] err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 8'd0;
        end else if (bus.DRTS && parity_odd(bus.RX) && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign rx_err_cnt = err_q;
`else
    logic unused_rx_parity;
    assign unused_rx_parity = bus.RX[0];
    assign rx_err_cnt       = 8'd0;
`endif
endmodule
